rf_seq_ctrl: RTL and testbench
==============================

Name: rf_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16x16-bit register file (A/B read ports, C write port, Load, clear).
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Drives register addresses, write enable, ALU opcode and C-source select.
- Handles memory load/store waits with a timeout watchdog, and sequences whole-file clears.

Parameters:
- MEM_TIMEOUT, 15, cycles waited for mem_ack before abort (1..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt; imm8 = [7:0].
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  controller can accept an instruction.
- clr_req  in  1  request to zero all 16 registers.
- resume  in  1  leave HALTED.
- mem_ack  in  1  memory done; read data is valid in the same cycle.
- Aaddr  out  4  register file A read address (= rs).
- Baddr  out  4  register file B read address (= rt).
- Caddr  out  4  register file write address (= rd).
- Load  out  1  register file write enable.
- clear  out  1  register file synchronous clear.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 PASS-A.
- c_sel  out  2  C-source mux: 0 ALU, 1 imm, 2 mem.
- imm  out  16  zero-extended imm8.
- mem_req  out  1  memory access request; address is A.
- mem_we  out  1  store when 1; data is B.
- busy  out  1  state is not IDLE.
- halted  out  1  state is HALTED.
- illegal  out  1  sticky; set by an undefined opcode.
- mem_err  out  1  sticky; set by a memory timeout.
- instr_count  out  CNT_W  number of retired instructions; wraps.

Behaviour:
- Reset (clear_n=0): state=CLR, IR=0, timer=0, illegal=0, mem_err=0, instr_count=0.
- All outputs are Moore decodes of state/IR, except Load in MEM (see below).
  - During reset: clear=1, instr_ready=0, Load=0, mem_req=0, Aaddr=Baddr=Caddr=0.
- CLR: clear=1 for exactly one cycle, then IDLE.
  - The first cycle after reset release is therefore a file clear.
- IDLE: instr_ready=1.
  - clr_req has priority over instr_valid: go to CLR and do not accept the instruction.
  - Otherwise, on instr_valid, IR<=instr and go to DEC.
- DEC: Aaddr=IR.rs and Baddr=IR.rt. These stay stable through EXEC/MEM.
  - Opcode decode selects the next state.
  - Opcodes 0-7 (ALU) and 8 (LDI) go to EXEC.
  - 9 (LD) and A (ST) go to MEM.
  - B (MOV) goes to EXEC with alu_op=PASS-A.
  - C (NOP) retires and returns to IDLE.
  - F (HALT) retires and goes to HALTED.
  - D, E set illegal, retire as NOP, and return to IDLE.
- EXEC: one cycle with Load=1 and Caddr=rd.
  - ALU ops use c_sel=0; LDI uses c_sel=1 and imm={8'h00, imm8}.
  - The instruction retires and the state returns to IDLE.
- Latency, accept cycle to write cycle: ALU/LDI/MOV = 2 cycles after acceptance; 3 cycles per instruction including IDLE.
- MEM: mem_req=1; mem_we=1 for ST. The timer increments each cycle.
  - mem_ack in MEM:
    - LD: Load=1, c_sel=2, Caddr=rd in the same cycle (combinational on mem_ack).
    - Both LD and ST: retire and go to IDLE.
  - If timer reaches MEM_TIMEOUT with no ack: set mem_err, Load=0, do not retire, go to IDLE.
  - The timer clears on exit from MEM.
  - An ack arriving on the timeout cycle wins.
- HALTED: instr_ready=0. resume goes to IDLE; clr_req goes to CLR and then IDLE. clr_req has priority.
- A retire increments instr_count by 1 modulo 2^CNT_W. A timeout does not retire.
- illegal and mem_err clear only on reset.
- clr_req outside IDLE/HALTED is ignored; the requester must hold it.
- rd=rs is legal: the read happens before the write, and the register file write is at the clock edge.
- Asserting clear_n mid-instruction aborts immediately: the instruction is not retired and no Load is issued.

Test Plan:
- Reset release -> clear=1 for 1 cycle, then instr_ready=1 and instr_count=0.
- LDI r3,0x5A -> Load=1, Caddr=3, c_sel=1, imm=0x005A exactly 2 cycles after handshake; instr_count=1.
- ADD r4,r1,r2 (instr=0x0412) -> DEC shows Aaddr=1, Baddr=2; EXEC shows Load=1, Caddr=4, alu_op=0, c_sel=0.
- LD r5,[r6] (0x956x) with mem_ack 4 cycles later -> mem_req held 4 cycles; Load=1, Caddr=5, c_sel=2 in the ack cycle. Then ST with no ack -> mem_err=1 after 15 cycles, instr_count unchanged.
- clr_req and instr_valid together in IDLE -> CLR (clear=1), instruction not accepted. Then HALT (0xF000) -> halted=1 and instr_ready=0 until resume.
- Opcode 0xD -> illegal=1 sticky, no Load. clear_n pulse during MEM -> mem_req=0 immediately and the CLR cycle follows.

Source files
------------

// File: rtl/rf_seq_ctrl_if.sv
// rtl/rf_seq_ctrl_if.sv - instruction handshake and memory request bus for rf_seq_ctrl
interface rf_seq_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;

    // master: instruction source and memory responder
    modport master (
        output instr,
        output instr_valid,
        input  instr_ready,
        input  mem_req,
        input  mem_we,
        output mem_ack
    );

    // slave: the sequencer
    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready,
        output mem_req,
        output mem_we,
        input  mem_ack
    );
endinterface

// File: rtl/rf_seq_ctrl.sv
// rtl/rf_seq_ctrl.sv - multi-cycle sequencer for a 16x16 register file with memory wait watchdog
module rf_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    rf_seq_ctrl_if.slave     bus,
    input  logic             clr_req,
    input  logic             resume,
    output logic [3:0]       Aaddr,
    output logic [3:0]       Baddr,
    output logic [3:0]       Caddr,
    output logic             Load,
    output logic             clear,
    output logic [2:0]       alu_op,
    output logic [1:0]       c_sel,
    output logic [15:0]      imm,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_DEC,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS_A = 3'd7;
    localparam logic [1:0] CSEL_ALU   = 2'd0;
    localparam logic [1:0] CSEL_IMM   = 2'd1;
    localparam logic [1:0] CSEL_MEM   = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_ir;
    logic [7:0]       r_timer;
    logic             r_illegal;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       w_op;
    logic             w_load_ir;
    logic             w_retire;
    logic             w_set_illegal;
    logic             w_set_mem_err;
    logic             w_timeout;
    logic             w_mem_ack;

    assign w_op      = r_ir[15:12];
    assign w_mem_ack = bus.mem_ack;
    assign w_timeout = (r_timer == TMO_LAST);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_CLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_ir     = 1'b0;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_mem_err = 1'b0;
        case (r_state)
            S_CLR: begin
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLR;
                end else if (bus.instr_valid) begin
                    w_load_ir   = 1'b1;
                    w_state_nxt = S_DEC;
                end
            end
            S_DEC: begin
                if (w_op <= OP_LDI || w_op == OP_MOV) begin
                    w_state_nxt = S_EXEC;
                end else if (w_op == OP_LD || w_op == OP_ST) begin
                    w_state_nxt = S_MEM;
                end else if (w_op == OP_HALT) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_HALTED;
                end else begin
                    // NOP and the undefined opcodes D/E all retire without a write
                    w_retire      = 1'b1;
                    w_set_illegal = (w_op != OP_NOP);
                    w_state_nxt   = S_IDLE;
                end
            end
            S_EXEC: begin
                w_retire    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_MEM: begin
                // an ack on the final watchdog cycle still completes the access
                if (w_mem_ack) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_set_mem_err = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_HALTED: begin
                if (clr_req) begin
                    w_state_nxt = S_CLR;
                end else if (resume) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_ir <= 16'h0000;
        end else if (w_load_ir) begin
            r_ir <= bus.instr;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_timer <= 8'd0;
        end else if (r_state == S_MEM && w_state_nxt == S_MEM) begin
            r_timer <= r_timer + 8'd1;
        end else begin
            r_timer <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_mem_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        bus.instr_ready = (r_state == S_IDLE);
        bus.mem_req     = (r_state == S_MEM);
        bus.mem_we      = (r_state == S_MEM) && (w_op == OP_ST);
        clear           = (r_state == S_CLR);
        busy            = (r_state != S_IDLE);
        halted          = (r_state == S_HALTED);
        Aaddr           = r_ir[7:4];
        Baddr           = r_ir[3:0];
        Caddr           = r_ir[11:8];
        imm             = {8'h00, r_ir[7:0]};
        alu_op          = (w_op <= 4'h7) ? w_op[2:0] : ALU_PASS_A;
        c_sel           = CSEL_ALU;
        if (r_state == S_MEM) begin
            c_sel = CSEL_MEM;
        end else if (w_op == OP_LDI) begin
            c_sel = CSEL_IMM;
        end
        // the load write is the only output that follows an input combinationally
        Load = (r_state == S_EXEC) ||
               ((r_state == S_MEM) && (w_op == OP_LD) && w_mem_ack);
    end

    assign illegal     = r_illegal;
    assign mem_err     = r_mem_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb/tb_rf_seq_ctrl.sv - directed and randomized checks of rf_seq_ctrl against an instruction-level model
module tb_rf_seq_ctrl;
    localparam int TMO = 15;

    logic        clk;
    logic        clear_n;
    logic        clr_req;
    logic        resume;
    logic [3:0]  Aaddr;
    logic [3:0]  Baddr;
    logic [3:0]  Caddr;
    logic        Load;
    logic        clear;
    logic [2:0]  alu_op;
    logic [1:0]  c_sel;
    logic [15:0] imm;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        mem_err;
    logic [15:0] instr_count;

    rf_seq_ctrl_if bus ();

    rf_seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .bus         (bus.slave),
        .clr_req     (clr_req),
        .resume      (resume),
        .Aaddr       (Aaddr),
        .Baddr       (Baddr),
        .Caddr       (Caddr),
        .Load        (Load),
        .clear       (clear),
        .alu_op      (alu_op),
        .c_sel       (c_sel),
        .imm         (imm),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instruction-level model state
    logic [15:0] m_count;
    logic        m_illegal;
    logic        m_mem_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = 16'd0;
        m_illegal = 1'b0;
        m_mem_err = 1'b0;
    endtask

    // Issues one instruction at an IDLE negedge, watches it to completion and
    // compares the observed write/memory behaviour with what the opcode rules predict.
    task automatic run_instr(input logic [15:0] ins, input int ack_dly);
        logic [3:0]  op;
        int          n;
        int          load_cyc;
        int          req_cnt;
        int          exp_load;
        int          exp_req;
        logic [1:0]  exp_csel;
        logic        retire;
        logic [3:0]  ld_caddr;
        logic [1:0]  ld_csel;
        logic [2:0]  ld_alu;
        logic [15:0] ld_imm;
        logic        we_ok;
        logic        done;
        op = ins[15:12];
        n  = 0;
        while (!bus.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(bus.instr_ready), 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("dec_aaddr", 32'(Aaddr), 32'(ins[7:4]));
        chk("dec_baddr", 32'(Baddr), 32'(ins[3:0]));
        load_cyc = -1;
        req_cnt  = 0;
        we_ok    = 1'b1;
        done     = 1'b0;
        ld_caddr = '0;
        ld_csel  = '0;
        ld_alu   = '0;
        ld_imm   = '0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.mem_req) begin
                req_cnt++;
                if (bus.mem_we !== (op == 4'hA)) we_ok = 1'b0;
            end
            bus.mem_ack = bus.mem_req && (req_cnt == ack_dly);
            #1;
            if (Load) begin
                load_cyc = c;
                ld_caddr = Caddr;
                ld_csel  = c_sel;
                ld_alu   = alu_op;
                ld_imm   = imm;
            end
            if (c >= 2 && (!busy || halted)) done = 1'b1;
        end
        bus.mem_ack = 1'b0;
        chk("instr_done", 32'(done), 32'd1);

        exp_load = -1;
        exp_req  = 0;
        exp_csel = 2'd0;
        retire   = 1'b1;
        if (op <= 4'h8 || op == 4'hB) begin
            exp_load = 2;
            exp_csel = (op == 4'h8) ? 2'd1 : 2'd0;
        end else if (op == 4'h9 || op == 4'hA) begin
            if (ack_dly >= 1 && ack_dly <= TMO) begin
                exp_req = ack_dly;
                if (op == 4'h9) begin
                    exp_load = 1 + ack_dly;
                    exp_csel = 2'd2;
                end
            end else begin
                exp_req   = TMO;
                retire    = 1'b0;
                m_mem_err = 1'b1;
            end
        end else if (op == 4'hD || op == 4'hE) begin
            m_illegal = 1'b1;
        end
        if (retire) m_count = m_count + 16'd1;

        chk("load_cycle", 32'(load_cyc), 32'(exp_load));
        chk("mem_req_cycles", 32'(req_cnt), 32'(exp_req));
        chk("mem_we", 32'(we_ok), 32'd1);
        if (exp_load >= 0) begin
            chk("caddr", 32'(ld_caddr), 32'(ins[11:8]));
            chk("c_sel", 32'(ld_csel), 32'(exp_csel));
            if (op <= 4'h7) chk("alu_op", 32'(ld_alu), 32'(op));
            if (op == 4'hB) chk("alu_op_mov", 32'(ld_alu), 32'd7);
            if (op == 4'h8) chk("imm", 32'(ld_imm), {24'h0, ins[7:0]});
        end
        chk("instr_count", 32'(instr_count), 32'(m_count));
        chk("illegal", 32'(illegal), 32'(m_illegal));
        chk("mem_err", 32'(mem_err), 32'(m_mem_err));
        chk("halted", 32'(halted), 32'(op == 4'hF));
    endtask

    task automatic do_resume();
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("resume_ready", 32'(bus.instr_ready), 32'd1);
        chk("resume_halted", 32'(halted), 32'd0);
    endtask

    initial begin
        logic [15:0] rins;
        int          rdly;
        clear_n         = 1'b0;
        clr_req         = 1'b0;
        resume          = 1'b0;
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_clear", 32'(clear), 32'd1);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_load", 32'(Load), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addrs", {20'h0, Aaddr, Baddr, Caddr}, 32'd0);
        @(posedge clk);
        #1 clear_n = 1'b1;
        @(negedge clk);
        chk("rel_clear", 32'(clear), 32'd1);
        chk("rel_not_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        chk("rel_clear_done", 32'(clear), 32'd0);
        chk("rel_ready", 32'(bus.instr_ready), 32'd1);
        chk("rel_count", 32'(instr_count), 32'd0);

        // directed instructions
        run_instr(16'h835A, 0);
        run_instr(16'h0412, 0);
        run_instr(16'h9560, 4);
        run_instr(16'hA000, 100);
        run_instr(16'h9781, TMO);
        run_instr(16'hA123, TMO + 1);
        run_instr(16'hB270, 0);

        // clr_req beats instr_valid in IDLE
        bus.instr       = 16'h8AFF;
        bus.instr_valid = 1'b1;
        clr_req         = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        clr_req         = 1'b0;
        chk("clrreq_clear", 32'(clear), 32'd1);
        chk("clrreq_not_dec", 32'(Caddr), 32'h2);
        @(negedge clk);
        chk("clrreq_ready", 32'(bus.instr_ready), 32'd1);
        chk("clrreq_count", 32'(instr_count), 32'(m_count));

        // HALT holds until resume
        run_instr(16'hF000, 0);
        repeat (3) @(negedge clk);
        chk("halt_hold_ready", 32'(bus.instr_ready), 32'd0);
        chk("halt_hold", 32'(halted), 32'd1);
        do_resume();

        // HALT left through clr_req, with clr_req beating resume
        run_instr(16'hF000, 0);
        clr_req = 1'b1;
        resume  = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        resume  = 1'b0;
        chk("halt_clr_clear", 32'(clear), 32'd1);
        chk("halt_clr_halted", 32'(halted), 32'd0);
        @(negedge clk);
        chk("halt_clr_ready", 32'(bus.instr_ready), 32'd1);

        // undefined opcodes
        run_instr(16'hD123, 0);
        run_instr(16'hC000, 0);
        run_instr(16'hE456, 0);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            rins = 16'($urandom);
            rdly = $urandom_range(1, TMO + 3);
            run_instr(rins, rdly);
            if (rins[15:12] == 4'hF) do_resume();
        end

        // reset in the middle of a memory wait
        @(negedge clk);
        bus.instr       = 16'h9120;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("mid_mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        model_reset();
        chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
        chk("abort_load", 32'(Load), 32'd0);
        chk("abort_clear", 32'(clear), 32'd1);
        chk("abort_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 clear_n = 1'b1;
        @(negedge clk);
        chk("abort_clr_cycle", 32'(clear), 32'd1);
        @(negedge clk);
        chk("abort_idle", 32'(bus.instr_ready), 32'd1);
        chk("abort_flags", {30'h0, illegal, mem_err}, 32'd0);
        run_instr(16'h8A11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
